tl_ul_arbiter_2to1: RTL and testbench
=====================================

Name: tl_ul_arbiter_2to1

Overview:
- Arbitrates two TileLink-UL masters (32-bit data, single-beat) onto one slave port.
- Typical use: sharing a peripheral/bus pass-through port between the core data port and a debug/DMA requester.
- A-channel arbitration:
  - round-robin between the two masters;
  - grant locked while a request is stalled;
  - optional per-master outstanding-request limit.
- D-channel responses are routed back using one source bit that the arbiter appends on the A channel.

Parameters:
- SRC_W, 2, master source-ID width. Slave source width is SRC_W+1.
- ADDR_W, 30, A-channel address width.
- MAX_OUT, 4, maximum in-flight requests per master (1..15).

Ports:
- clock  input  1  sole clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- mN_a_valid  input  1  master N A-request valid (N=0,1; same for all mN_ ports below).
- mN_a_ready  output  1  master N A accepted.
- mN_a_opcode / mN_a_param / mN_a_size  input  3 each  A fields.
- mN_a_source  input  SRC_W  master source ID.
- mN_a_address  input  ADDR_W  address.
- mN_a_mask  input  4  byte mask.
- mN_a_data  input  32  write data.
- mN_d_valid  output  1  response valid to master N.
- mN_d_ready  input  1  master N accepts response.
- mN_d_opcode  output  3  D field.
- mN_d_param  output  2  D field.
- mN_d_size  output  3  D field.
- mN_d_source  output  SRC_W  slave d_source[SRC_W-1:0].
- mN_d_sink / mN_d_denied / mN_d_corrupt  output  1 each  D fields.
- mN_d_data  output  32  read data.
- s_a_*  output  A fields toward the slave (same widths as mN_a_*, except s_a_source is SRC_W+1).
- s_a_valid  output  1  request valid to the slave.
- s_a_ready  input  1  slave accepts the request.
- s_d_*  input  D fields from the slave (s_d_source is SRC_W+1).
- s_d_valid  input  1  response valid from the slave.
- s_d_ready  output  1  arbiter accepts the response.

Behaviour:
- State registers:
  - last_gnt: 1 bit, reset 1 (so m0 wins the first tie).
  - hold: 1 bit, reset 0.
  - held_gnt: 1 bit, reset 0.
  - cnt0, cnt1: 4 bits each, reset 0.
- All outputs are combinational from state and inputs.
- While reset is asserted, every valid/ready output is 0.
- Eligibility: elig_N = mN_a_valid & (cnt_N != MAX_OUT).
- Grant selection, in priority order:
  - If hold=1: gnt = held_gnt, regardless of eligibility.
  - Else if both masters eligible: gnt = ~last_gnt.
  - Else if exactly one eligible: gnt = that master.
  - Else: no grant.
- A-channel outputs:
  - s_a_valid = a grant exists.
  - s_a_* fields = the granted master's fields.
  - s_a_source = {gnt, mGNT_a_source}.
- mN_a_ready = s_a_ready & s_a_valid & (gnt==N). The non-granted master's ready is 0.
- A fire (s_a_valid & s_a_ready):
  - last_gnt <= gnt;
  - hold <= 0.
- Stall (s_a_valid & ~s_a_ready):
  - hold <= 1;
  - held_gnt <= gnt.
  - This keeps the grant stable, as TileLink requires valid/payload to be held until accepted.
- Zero-latency path: a request presented with s_a_ready=1 fires in the same cycle. There are no pipeline registers.
- D-channel routing:
  - sel = s_d_source[SRC_W].
  - mN_d_valid = s_d_valid & (sel==N).
  - s_d_ready = m(sel)_d_ready.
  - D fields are broadcast to both masters; only the valid is steered.
- Counters:
  - cnt_N increments on an A fire from master N.
  - cnt_N decrements on a D fire to master N.
  - Increment and decrement in the same cycle: counter unchanged.
  - Counter never exceeds MAX_OUT, because master N is ineligible at the limit.
- A D fire with cnt_N==0 is a protocol error: the counter stays at 0 (no wrap).
  - Simulation-only assertion fires in this case.
- A-channel and D-channel are independent; simultaneous A fire and D fire on either master is legal.
- Reset asserted mid-transaction clears hold and the counters immediately. Slave responses in flight at that point are the system's responsibility.

Optional Feature:
- Macro: TL_ARB_PERF_EN.
- When defined, adds output ports perf_gnt0 and perf_gnt1 (32 bits each):
  - perf_gnt0 counts A fires of m0; perf_gnt1 counts A fires of m1;
  - both wrap modulo 2^32 and reset to 0;
  - also adds output perf_stall (32 bits): counts cycles with s_a_valid & ~s_a_ready.
- When not defined, these ports and registers are absent and behaviour is otherwise identical.

Test Plan:
- Single master: m0 issues Get (address 0x100, source 1) with s_a_ready=1 → s_a_valid in the same cycle, s_a_source=3'b001, m0_a_ready=1. Slave returns d_source=3'b001 → m0_d_valid=1, m0_d_source=2'b01, m1_d_valid=0.
- Contention: both masters valid every cycle for 6 cycles, s_a_ready=1 → grants alternate m0,m1,m0,m1,m0,m1.
- Stall lock: both valid, s_a_ready=0 for 3 cycles then 1 → grant stays on m0 through the stall, fires on cycle 4, then m1 wins.
- Outstanding limit (MAX_OUT=4): m0 issues 4 requests with no D responses → cnt0=4, further m0 requests not granted while m1 still proceeds. One D response to m0 → m0 is granted the next cycle.
- D routing/backpressure: slave d_source=3'b110 with m1_d_ready=0 → s_d_ready=0 and m1_d_valid=1. Raise m1_d_ready → s_d_ready=1 and cnt1 decrements.
- Async reset: reset asserted while hold=1 and cnt0=2 → immediately hold=0, cnt0=0, all valid/ready outputs 0. After release, the first tie goes to m0.

Source files
------------

// File: rtl/tl_ul_arbiter_2to1.sv
// Two-master TileLink-UL arbiter: round-robin A channel with stall lock and per-master
// outstanding limit; D responses steered by the appended source MSB. Option: TL_ARB_PERF_EN.
module tl_ul_arbiter_2to1 #(
    parameter int unsigned SRC_W   = 2,
    parameter int unsigned ADDR_W  = 30,
    parameter int unsigned MAX_OUT = 4
) (
    input  logic              clock,
    input  logic              reset,
`ifdef TL_ARB_PERF_EN
    output logic [31:0]       perf_gnt0,
    output logic [31:0]       perf_gnt1,
    output logic [31:0]       perf_stall,
`endif
    input  logic              m0_a_valid,
    output logic              m0_a_ready,
    input  logic [2:0]        m0_a_opcode,
    input  logic [2:0]        m0_a_param,
    input  logic [2:0]        m0_a_size,
    input  logic [SRC_W-1:0]  m0_a_source,
    input  logic [ADDR_W-1:0] m0_a_address,
    input  logic [3:0]        m0_a_mask,
    input  logic [31:0]       m0_a_data,
    output logic              m0_d_valid,
    input  logic              m0_d_ready,
    output logic [2:0]        m0_d_opcode,
    output logic [1:0]        m0_d_param,
    output logic [2:0]        m0_d_size,
    output logic [SRC_W-1:0]  m0_d_source,
    output logic              m0_d_sink,
    output logic              m0_d_denied,
    output logic              m0_d_corrupt,
    output logic [31:0]       m0_d_data,
    input  logic              m1_a_valid,
    output logic              m1_a_ready,
    input  logic [2:0]        m1_a_opcode,
    input  logic [2:0]        m1_a_param,
    input  logic [2:0]        m1_a_size,
    input  logic [SRC_W-1:0]  m1_a_source,
    input  logic [ADDR_W-1:0] m1_a_address,
    input  logic [3:0]        m1_a_mask,
    input  logic [31:0]       m1_a_data,
    output logic              m1_d_valid,
    input  logic              m1_d_ready,
    output logic [2:0]        m1_d_opcode,
    output logic [1:0]        m1_d_param,
    output logic [2:0]        m1_d_size,
    output logic [SRC_W-1:0]  m1_d_source,
    output logic              m1_d_sink,
    output logic              m1_d_denied,
    output logic              m1_d_corrupt,
    output logic [31:0]       m1_d_data,
    output logic              s_a_valid,
    input  logic              s_a_ready,
    output logic [2:0]        s_a_opcode,
    output logic [2:0]        s_a_param,
    output logic [2:0]        s_a_size,
    output logic [SRC_W:0]    s_a_source,
    output logic [ADDR_W-1:0] s_a_address,
    output logic [3:0]        s_a_mask,
    output logic [31:0]       s_a_data,
    input  logic              s_d_valid,
    output logic              s_d_ready,
    input  logic [2:0]        s_d_opcode,
    input  logic [1:0]        s_d_param,
    input  logic [2:0]        s_d_size,
    input  logic [SRC_W:0]    s_d_source,
    input  logic              s_d_sink,
    input  logic              s_d_denied,
    input  logic              s_d_corrupt,
    input  logic [31:0]       s_d_data
);

    localparam logic [3:0] MaxOut = 4'(MAX_OUT);

    logic       r_last_gnt, r_hold, r_held_gnt;
    logic [3:0] r_cnt0, r_cnt1;
    logic [3:0] w_cnt0_d, w_cnt1_d;
    logic       w_elig0, w_elig1, w_gnt, w_gnt_vld;
    logic       w_a_fire, w_sel, w_inc0, w_inc1, w_dec0, w_dec1;

    assign w_elig0 = m0_a_valid & (r_cnt0 != MaxOut);
    assign w_elig1 = m1_a_valid & (r_cnt1 != MaxOut);

    // A held grant wins unconditionally so the stalled payload stays stable.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt     = 1'b0;
        if (r_hold) begin
            w_gnt_vld = 1'b1;
            w_gnt     = r_held_gnt;
        end else if (w_elig0 && w_elig1) begin
            w_gnt_vld = 1'b1;
            w_gnt     = ~r_last_gnt;
        end else if (w_elig0) begin
            w_gnt_vld = 1'b1;
        end else if (w_elig1) begin
            w_gnt_vld = 1'b1;
            w_gnt     = 1'b1;
        end
    end

    assign s_a_valid   = w_gnt_vld & ~reset;
    assign s_a_opcode  = w_gnt ? m1_a_opcode  : m0_a_opcode;
    assign s_a_param   = w_gnt ? m1_a_param   : m0_a_param;
    assign s_a_size    = w_gnt ? m1_a_size    : m0_a_size;
    assign s_a_source  = {w_gnt, (w_gnt ? m1_a_source : m0_a_source)};
    assign s_a_address = w_gnt ? m1_a_address : m0_a_address;
    assign s_a_mask    = w_gnt ? m1_a_mask    : m0_a_mask;
    assign s_a_data    = w_gnt ? m1_a_data    : m0_a_data;
    assign m0_a_ready  = s_a_ready & s_a_valid & ~w_gnt;
    assign m1_a_ready  = s_a_ready & s_a_valid & w_gnt;
    assign w_a_fire    = s_a_valid & s_a_ready;

    assign w_sel       = s_d_source[SRC_W];
    assign m0_d_valid  = s_d_valid & ~w_sel & ~reset;
    assign m1_d_valid  = s_d_valid & w_sel & ~reset;
    assign s_d_ready   = (w_sel ? m1_d_ready : m0_d_ready) & ~reset;

    assign m0_d_opcode  = s_d_opcode;
    assign m0_d_param   = s_d_param;
    assign m0_d_size    = s_d_size;
    assign m0_d_source  = s_d_source[SRC_W-1:0];
    assign m0_d_sink    = s_d_sink;
    assign m0_d_denied  = s_d_denied;
    assign m0_d_corrupt = s_d_corrupt;
    assign m0_d_data    = s_d_data;
    assign m1_d_opcode  = s_d_opcode;
    assign m1_d_param   = s_d_param;
    assign m1_d_size    = s_d_size;
    assign m1_d_source  = s_d_source[SRC_W-1:0];
    assign m1_d_sink    = s_d_sink;
    assign m1_d_denied  = s_d_denied;
    assign m1_d_corrupt = s_d_corrupt;
    assign m1_d_data    = s_d_data;

    assign w_inc0 = w_a_fire & ~w_gnt;
    assign w_inc1 = w_a_fire & w_gnt;
    assign w_dec0 = m0_d_valid & m0_d_ready;
    assign w_dec1 = m1_d_valid & m1_d_ready;

    // A decrement at zero is a protocol error; saturate rather than wrap.
    always_comb begin
        w_cnt0_d = r_cnt0;
        w_cnt1_d = r_cnt1;
        if (w_inc0 && !w_dec0) begin
            w_cnt0_d = r_cnt0 + 4'd1;
        end else if (!w_inc0 && w_dec0 && (r_cnt0 != 4'd0)) begin
            w_cnt0_d = r_cnt0 - 4'd1;
        end
        if (w_inc1 && !w_dec1) begin
            w_cnt1_d = r_cnt1 + 4'd1;
        end else if (!w_inc1 && w_dec1 && (r_cnt1 != 4'd0)) begin
            w_cnt1_d = r_cnt1 - 4'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_last_gnt <= 1'b1;
            r_hold     <= 1'b0;
            r_held_gnt <= 1'b0;
            r_cnt0     <= 4'd0;
            r_cnt1     <= 4'd0;
        end else begin
            if (w_a_fire) begin
                r_last_gnt <= w_gnt;
                r_hold     <= 1'b0;
            end else if (s_a_valid) begin
                r_hold     <= 1'b1;
                r_held_gnt <= w_gnt;
            end
            r_cnt0 <= w_cnt0_d;
            r_cnt1 <= w_cnt1_d;
        end
    end

`ifdef TL_ARB_PERF_EN
    logic [31:0] r_perf_gnt0, r_perf_gnt1, r_perf_stall;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_perf_gnt0  <= 32'd0;
            r_perf_gnt1  <= 32'd0;
            r_perf_stall <= 32'd0;
        end else begin
            if (w_inc0) r_perf_gnt0 <= r_perf_gnt0 + 32'd1;
            if (w_inc1) r_perf_gnt1 <= r_perf_gnt1 + 32'd1;
            if (s_a_valid && !s_a_ready) r_perf_stall <= r_perf_stall + 32'd1;
        end
    end

    assign perf_gnt0  = r_perf_gnt0;
    assign perf_gnt1  = r_perf_gnt1;
    assign perf_stall = r_perf_stall;
`endif

`ifndef SYNTHESIS
    a_d_underflow0: assert property (@(posedge clock) disable iff (reset)
        !(w_dec0 && (r_cnt0 == 4'd0)));
    a_d_underflow1: assert property (@(posedge clock) disable iff (reset)
        !(w_dec1 && (r_cnt1 == 4'd0)));
`endif

endmodule

// File: tb/tb_tl_ul_arbiter_2to1.sv
// Directed bench for tl_ul_arbiter_2to1: expected A grants and D deliveries are queued by the
// stimulus and popped by negedge monitors; a few same-cycle values are checked inline.
module tb_tl_ul_arbiter_2to1;
    logic        clock = 1'b0;
    logic        reset;
    logic        m0_a_valid, m0_a_ready, m1_a_valid, m1_a_ready;
    logic [2:0]  m0_a_opcode, m1_a_opcode, m0_a_param, m1_a_param, m0_a_size, m1_a_size;
    logic [1:0]  m0_a_source, m1_a_source;
    logic [29:0] m0_a_address, m1_a_address;
    logic [3:0]  m0_a_mask, m1_a_mask;
    logic [31:0] m0_a_data, m1_a_data;
    logic        m0_d_valid, m0_d_ready, m1_d_valid, m1_d_ready;
    logic [2:0]  m0_d_opcode, m1_d_opcode, m0_d_size, m1_d_size;
    logic [1:0]  m0_d_param, m1_d_param, m0_d_source, m1_d_source;
    logic        m0_d_sink, m1_d_sink, m0_d_denied, m1_d_denied, m0_d_corrupt, m1_d_corrupt;
    logic [31:0] m0_d_data, m1_d_data;
    logic        s_a_valid, s_a_ready;
    logic [2:0]  s_a_opcode, s_a_param, s_a_size;
    logic [2:0]  s_a_source;
    logic [29:0] s_a_address;
    logic [3:0]  s_a_mask;
    logic [31:0] s_a_data;
    logic        s_d_valid, s_d_ready;
    logic [2:0]  s_d_opcode, s_d_size, s_d_source;
    logic [1:0]  s_d_param;
    logic        s_d_sink, s_d_denied, s_d_corrupt;
    logic [31:0] s_d_data;

    int n_tests = 0;
    int n_fail  = 0;
    logic [34:0] a_q[$];   // {s_a_source, s_a_address, m0_a_ready, m1_a_ready}
    logic [37:0] d_q[$];   // {m0_d_valid, m1_d_valid, m0_d_source, m1_d_source, m1_d_data}

    tl_ul_arbiter_2to1 dut (
        .clock(clock), .reset(reset),
        .m0_a_valid(m0_a_valid), .m0_a_ready(m0_a_ready), .m0_a_opcode(m0_a_opcode),
        .m0_a_param(m0_a_param), .m0_a_size(m0_a_size), .m0_a_source(m0_a_source),
        .m0_a_address(m0_a_address), .m0_a_mask(m0_a_mask), .m0_a_data(m0_a_data),
        .m0_d_valid(m0_d_valid), .m0_d_ready(m0_d_ready), .m0_d_opcode(m0_d_opcode),
        .m0_d_param(m0_d_param), .m0_d_size(m0_d_size), .m0_d_source(m0_d_source),
        .m0_d_sink(m0_d_sink), .m0_d_denied(m0_d_denied), .m0_d_corrupt(m0_d_corrupt),
        .m0_d_data(m0_d_data),
        .m1_a_valid(m1_a_valid), .m1_a_ready(m1_a_ready), .m1_a_opcode(m1_a_opcode),
        .m1_a_param(m1_a_param), .m1_a_size(m1_a_size), .m1_a_source(m1_a_source),
        .m1_a_address(m1_a_address), .m1_a_mask(m1_a_mask), .m1_a_data(m1_a_data),
        .m1_d_valid(m1_d_valid), .m1_d_ready(m1_d_ready), .m1_d_opcode(m1_d_opcode),
        .m1_d_param(m1_d_param), .m1_d_size(m1_d_size), .m1_d_source(m1_d_source),
        .m1_d_sink(m1_d_sink), .m1_d_denied(m1_d_denied), .m1_d_corrupt(m1_d_corrupt),
        .m1_d_data(m1_d_data),
        .s_a_valid(s_a_valid), .s_a_ready(s_a_ready), .s_a_opcode(s_a_opcode),
        .s_a_param(s_a_param), .s_a_size(s_a_size), .s_a_source(s_a_source),
        .s_a_address(s_a_address), .s_a_mask(s_a_mask), .s_a_data(s_a_data),
        .s_d_valid(s_d_valid), .s_d_ready(s_d_ready), .s_d_opcode(s_d_opcode),
        .s_d_param(s_d_param), .s_d_size(s_d_size), .s_d_source(s_d_source),
        .s_d_sink(s_d_sink), .s_d_denied(s_d_denied), .s_d_corrupt(s_d_corrupt),
        .s_d_data(s_d_data)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitors: every A fire / D fire must match the next queued expectation.
    always @(negedge clock) begin
        if (!reset && s_a_valid && s_a_ready) begin
            if (a_q.size() == 0) begin
                check("a_unexpected_fire", 64'(s_a_source), 64'hFFFF);
            end else begin
                check("a_fire", 64'({s_a_source, s_a_address, m0_a_ready, m1_a_ready}),
                      64'(a_q.pop_front()));
            end
        end
        if (!reset && s_d_valid && s_d_ready) begin
            if (d_q.size() == 0) begin
                check("d_unexpected_fire", 64'(s_d_source), 64'hFFFF);
            end else begin
                check("d_fire", 64'({m0_d_valid, m1_d_valid, m0_d_source, m1_d_source,
                                     m1_d_data}), 64'(d_q.pop_front()));
            end
        end
    end

    task automatic push_a(input logic g, input logic [1:0] src, input logic [29:0] addr);
        a_q.push_back({g, src, addr, ~g, g});
    endtask

    task automatic push_d(input logic to1, input logic [1:0] src, input logic [31:0] data);
        d_q.push_back({~to1, to1, src, src, data});
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        m0_a_valid = 1'b0; m1_a_valid = 1'b0; s_a_ready = 1'b0;
        s_d_valid = 1'b0; m0_d_ready = 1'b0; m1_d_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

    task automatic drive_m0(input logic v, input logic [1:0] src, input logic [29:0] addr);
        m0_a_valid = v; m0_a_source = src; m0_a_address = addr;
    endtask

    task automatic drive_m1(input logic v, input logic [1:0] src, input logic [29:0] addr);
        m1_a_valid = v; m1_a_source = src; m1_a_address = addr;
    endtask

    initial begin
        m0_a_opcode = 3'd4; m1_a_opcode = 3'd4; m0_a_param = 3'd0; m1_a_param = 3'd0;
        m0_a_size = 3'd2; m1_a_size = 3'd2; m0_a_mask = 4'hF; m1_a_mask = 4'hF;
        m0_a_data = 32'h0; m1_a_data = 32'h0;
        m0_a_source = 2'd0; m1_a_source = 2'd0; m0_a_address = '0; m1_a_address = '0;
        s_d_opcode = 3'd1; s_d_param = 2'd0; s_d_size = 3'd2; s_d_source = 3'd0;
        s_d_sink = 1'b0; s_d_denied = 1'b0; s_d_corrupt = 1'b0; s_d_data = 32'h0;

        // Reset gates every valid/ready even with live inputs.
        reset = 1'b1;
        m0_a_valid = 1'b1; m1_a_valid = 1'b0; s_a_ready = 1'b1;
        s_d_valid = 1'b1; m0_d_ready = 1'b1; m1_d_ready = 1'b1;
        #2;
        check("rst_outputs", 64'({s_a_valid, m0_a_ready, m1_a_ready,
                                  m0_d_valid, m1_d_valid, s_d_ready}), 64'd0);
        idle_inputs();
        cyc();
        reset = 1'b0;

        // Single master Get, same-cycle fire, then routed response.
        drive_m0(1'b1, 2'd1, 30'h100); s_a_ready = 1'b1;
        push_a(1'b0, 2'd1, 30'h100);
        #1;
        check("single_same_cycle", 64'({s_a_valid, m0_a_ready, m1_a_ready}), 64'b110);
        cyc();
        m0_a_valid = 1'b0; s_a_ready = 1'b0;
        s_d_valid = 1'b1; s_d_source = 3'b001; s_d_data = 32'hCAFE_0001; m0_d_ready = 1'b1;
        push_d(1'b0, 2'b01, 32'hCAFE_0001);
        cyc();
        s_d_valid = 1'b0; m0_d_ready = 1'b0;
        check("single_cnt0", 64'(dut.r_cnt0), 64'd0);

        // Contention after reset: m0,m1,m0,m1,m0,m1.
        do_reset();
        drive_m0(1'b1, 2'd2, 30'h200); drive_m1(1'b1, 2'd3, 30'h300); s_a_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) push_a(1'b0, 2'd2, 30'h200);
            else            push_a(1'b1, 2'd3, 30'h300);
            cyc();
        end
        idle_inputs();
        check("contend_cnts", 64'({dut.r_cnt0, dut.r_cnt1}), 64'h33);

        // Stall lock: grant stays on m0 for 3 stalled cycles, fires, then m1.
        do_reset();
        drive_m0(1'b1, 2'd0, 30'h40); drive_m1(1'b1, 2'd1, 30'h50);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_payload", 64'({s_a_valid, s_a_source, s_a_address, m0_a_ready}),
                  64'({1'b1, 3'b000, 30'h40, 1'b0}));
            cyc();
            check("stall_hold", 64'(dut.r_hold), 64'd1);
        end
        s_a_ready = 1'b1;
        push_a(1'b0, 2'd0, 30'h40);
        cyc();
        push_a(1'b1, 2'd1, 30'h50);
        cyc();
        idle_inputs();

        // Outstanding limit: 4 m0 fires, m0 blocked while m1 proceeds, freed by a response.
        do_reset();
        s_a_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_m0(1'b1, 2'd0, 30'h10 + 30'(i));
            push_a(1'b0, 2'd0, 30'h10 + 30'(i));
            cyc();
        end
        drive_m0(1'b1, 2'd0, 30'h20); drive_m1(1'b1, 2'd2, 30'h80);
        push_a(1'b1, 2'd2, 30'h80);
        cyc();
        m1_a_valid = 1'b0;
        s_d_valid = 1'b1; s_d_source = 3'b000; s_d_data = 32'h0000_D00D; m0_d_ready = 1'b1;
        push_d(1'b0, 2'b00, 32'h0000_D00D);
        #1;
        check("limit_blocked", 64'({s_a_valid, m0_a_ready}), 64'd0);
        cyc();
        s_d_valid = 1'b0; m0_d_ready = 1'b0;
        push_a(1'b0, 2'd0, 30'h20);
        cyc();
        idle_inputs();
        check("limit_cnts", 64'({dut.r_cnt0, dut.r_cnt1}), 64'h41);

        // D backpressure to m1, then release.
        s_d_valid = 1'b1; s_d_source = 3'b110; s_d_data = 32'hBEEF_0110;
        m0_d_ready = 1'b1; m1_d_ready = 1'b0;
        #1;
        check("d_backpressure", 64'({s_d_ready, m0_d_valid, m1_d_valid, m1_d_source}),
              64'({1'b0, 1'b0, 1'b1, 2'b10}));
        cyc();
        m1_d_ready = 1'b1;
        push_d(1'b1, 2'b10, 32'hBEEF_0110);
        cyc();
        idle_inputs();
        check("d_cnt1_dec", 64'(dut.r_cnt1), 64'd0);

        // Async reset while hold=1 and cnt0=2.
        do_reset();
        s_a_ready = 1'b1;
        drive_m0(1'b1, 2'd1, 30'h60);
        push_a(1'b0, 2'd1, 30'h60);
        cyc();
        push_a(1'b0, 2'd1, 30'h60);
        cyc();
        drive_m1(1'b1, 2'd3, 30'h70); s_a_ready = 1'b0;
        cyc();
        check("pre_rst_state", 64'({dut.r_hold, dut.r_cnt0}), 64'h12);
        s_a_ready = 1'b1; s_d_valid = 1'b1; s_d_source = 3'b000; m0_d_ready = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_state", 64'({dut.r_hold, dut.r_cnt0}), 64'h00);
        check("async_rst_outputs", 64'({s_a_valid, m0_a_ready, m1_a_ready,
                                        m0_d_valid, m1_d_valid, s_d_ready}), 64'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        s_d_valid = 1'b0; m0_d_ready = 1'b0;
        push_a(1'b0, 2'd1, 30'h60);
        cyc();
        idle_inputs();

        repeat (3) cyc();
        check("a_queue_drained", 64'(a_q.size()), 64'd0);
        check("d_queue_drained", 64'(d_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1, "timeout");
    end
endmodule
